// File: rtl/fpdp_power_sequencer.sv
// Right-to-left square-and-multiply sequencer computing base^exp on a shared external fpdp multiplier.
// Optional multiplier-wait timeout with err flag: define FPDP_POW_TIMEOUT_EN.
module fpdp_power_sequencer #(
    parameter int EXP_W       = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rset,
    input  logic             start,
    input  logic [63:0]      base,
    input  logic [EXP_W-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [63:0]      result,
    output logic             err,
    output logic             mul_start,
    output logic [63:0]      mul_a,
    output logic [63:0]      mul_b,
    input  logic             mul_done,
    input  logic [63:0]      mul_p
);

    localparam logic [63:0] FP_ONE = 64'h3FF0_0000_0000_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHK    = 3'd1,
        ISS_M  = 3'd2,
        WAIT_M = 3'd3,
        ISS_S  = 3'd4,
        WAIT_S = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [63:0]        base_r;
    logic [EXP_W-1:0]   exp_r;
    logic [63:0]        acc;
    logic               timeout_hit;

    if (TIMEOUT_CYC < 2) begin : g_timeout_range
        $error("TIMEOUT_CYC must be at least 2");
    end

    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mul_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CHK;
            end
            CHK: begin
                busy = 1'b1;
                if (exp_r == '0)   state_nxt = DONE;
                else if (exp_r[0]) state_nxt = ISS_M;
                else               state_nxt = ISS_S;
            end
            ISS_M: begin
                busy      = 1'b1;
                mul_start = 1'b1;
                state_nxt = WAIT_M;
            end
            ISS_S: begin
                busy      = 1'b1;
                mul_start = 1'b1;
                state_nxt = WAIT_S;
            end
            WAIT_M, WAIT_S: begin
                busy = 1'b1;
                if (mul_done)         state_nxt = CHK;
                else if (timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are loaded on the CHK->ISS edge so they are already valid while mul_start is high.
    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            base_r <= '0;
            exp_r  <= '0;
            acc    <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_r <= base;
                        exp_r  <= exp;
                        acc    <= FP_ONE;
                    end
                end
                CHK: begin
                    if (exp_r != '0) begin
                        if (exp_r[0]) begin
                            mul_a <= acc;
                            mul_b <= base_r;
                        end else begin
                            mul_a <= base_r;
                            mul_b <= base_r;
                        end
                    end
                end
                WAIT_M: begin
                    if (mul_done) begin
                        acc      <= mul_p;
                        exp_r[0] <= 1'b0;
                    end
                end
                WAIT_S: begin
                    if (mul_done) begin
                        base_r <= mul_p;
                        exp_r  <= exp_r >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = acc;

`ifdef FPDP_POW_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_r;

    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            wait_cnt <= '0;
        end else if (state == ISS_M || state == ISS_S) begin
            wait_cnt <= '0;
        end else if (state == WAIT_M || state == WAIT_S) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // ISS plus (TIMEOUT_CYC-1) wait cycles puts DONE exactly TIMEOUT_CYC cycles after mul_start.
    assign timeout_hit = (state == WAIT_M || state == WAIT_S) &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            err_r <= 1'b0;
        end else if (state == IDLE && start) begin
            err_r <= 1'b0;
        end else if (timeout_hit && !mul_done) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: doc/fpdp_power_sequencer.md
Name: fpdp_power_sequencer

Overview:
Sequences one shared IEEE-754 double-precision multiplier to compute base^exp, for an unsigned integer exp, by right-to-left binary (square-and-multiply) exponentiation. It sits beside the fpdp multiplier in the Nth-root datapath and produces the x^(n-1) / x^n terms for each root-finding iteration. The multiplier is external: this block issues operands with a start pulse and waits for its completion pulse.

Parameters:
EXP_W, 8, width of the integer exponent.
TIMEOUT_CYC, 64, maximum cycles to wait for mul_done; used only with FPDP_POW_TIMEOUT_EN.

Ports:
clk  input  1  clock; all state changes on rising edge.
rset  input  1  reset, asynchronous, active-high.
start  input  1  request; sampled only in IDLE.
base  input  64  fpdp base operand; captured when start is accepted.
exp  input  EXP_W  unsigned exponent; captured when start is accepted.
busy  output  1  high from the cycle after acceptance through DONE.
done  output  1  single-cycle pulse when result is valid.
result  output  64  fpdp base^exp; held until the next accepted start.
err  output  1  timeout flag; see Optional Feature.
mul_start  output  1  single-cycle pulse that launches the multiplier.
mul_a  output  64  multiplier operand A; stable from mul_start until mul_done.
mul_b  output  64  multiplier operand B; stable from mul_start until mul_done.
mul_done  input  1  multiplier completion pulse.
mul_p  input  64  multiplier product; valid in the cycle mul_done=1.

Behaviour:
- Reset, asynchronous and applicable mid-operation: state=IDLE. busy, done, err and mul_start=0. result, mul_a, mul_b, base_r and exp_r=0. Any in-flight multiply is abandoned.
- Internal registers: base_r (64), exp_r (EXP_W), acc (64). result is driven from acc.
- IDLE: if start=1, then base_r<=base, exp_r<=exp, acc<=64'h3FF0_0000_0000_0000 (1.0), err<=0, and go to CHK. start seen in any other state is ignored, with no queuing.
- CHK: if exp_r==0, go to DONE. Otherwise, if exp_r[0]=1, go to ISS_M. Otherwise go to ISS_S.
- ISS_M: mul_start=1 for this cycle, mul_a<=acc, mul_b<=base_r, then go to WAIT_M.
- WAIT_M: on mul_done, acc<=mul_p and exp_r[0]<=0, then go to CHK.
- ISS_S: mul_start=1 for this cycle, mul_a<=base_r, mul_b<=base_r, then go to WAIT_S.
- WAIT_S: on mul_done, base_r<=mul_p and exp_r<=exp_r>>1, then go to CHK.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE. busy drops in the IDLE cycle.
- mul_done outside WAIT_M or WAIT_S is ignored.
- A mul_done in the same cycle as mul_start (in ISS_*) is ignored. The multiplier is required to respond at least 1 cycle after mul_start.
- Multiply count equals popcount(exp) + floor(log2(exp)) for exp>0, and 0 for exp=0.
  - The first multiply, 1.0*base, is exact and is kept for uniformity.
- Latency:
  - exp=0: done is asserted 2 cycles after the start-accept edge.
  - Each multiply adds 1 (ISS) + W (wait until mul_done) + 1 (CHK) cycles.
- Sign, zero and exponent arithmetic belong to the multiplier. The sequencer never inspects operand bits.
- Without the macro, err is tied to 0.

Optional Feature:
FPDP_POW_TIMEOUT_EN.
- Defined:
  - A wait counter clears on each ISS_* state and increments in each WAIT_* state.
  - If it reaches TIMEOUT_CYC without mul_done, then err<=1, acc is left as-is, and the FSM goes to DONE.
  - err stays high until the next accepted start or reset.
- Undefined: the counter is not built, err=0, and WAIT_* states wait indefinitely.

Test Plan:
- base=0x4000000000000000 (2.0), exp=0 -> no mul_start pulse; done 2 cycles after accept; result=0x3FF0000000000000.
- base=2.0, exp=5, 3-cycle bench multiplier model -> exactly 4 mul_start pulses, with (a,b) in this order:
  - (1.0, 2.0)
  - (2.0, 2.0)
  - (4.0, 4.0)
  - (2.0, 16.0)
  - result=0x4040000000000000 (32.0).
- base=0xBFF8000000000000 (-1.5), exp=3 -> result=0xC00B000000000000 (-3.375); busy is high throughout; done is one cycle wide.
- start re-pulsed while busy, with exp=7 running -> second request ignored; result is base^7 from the first request only; exactly one done.
- rset asserted during WAIT_S of an exp=6 run -> all outputs 0 immediately; a new start with exp=2, base=3.0 -> result=0x4022000000000000 (9.0).
- With FPDP_POW_TIMEOUT_EN and a model that never returns mul_done -> err=1 and done pulse exactly TIMEOUT_CYC cycles after mul_start; a following good request clears err.
